// File: rtl/hysteresis_stream.sv
// Streaming hysteresis edge decision over a raster gradient image.
// Two line buffers and a shifting window form each pixel's 3x3
// neighbourhood. The decision for centre (r,c) is registered on the
// acceptance of pixel (r+1,c+1). After the last input pixel, the
// remaining outputs are emitted from FLUSH. Those outputs all lie on the
// image border, so they are zero.
module hysteresis_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] thresh_h,
    input  logic [PIX_W-1:0] thresh_l,
    input  logic             hyst_enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_edge,
    output logic             out_eof,
    output logic             sof_err
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int OW   = $clog2(NPIX + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    col, pos_c;
    logic [RW-1:0]    row, pos_r;
    logic [OW-1:0]    ocnt;
    logic [PIX_W-1:0] thr_h, thr_l;
    logic             hyst_r;

    logic [PIX_W-1:0] lb0 [IMG_W];  // previous line
    logic [PIX_W-1:0] lb1 [IMG_W];  // line before that

    // Window: two registered columns; the third is the incoming column
    // (lb1, lb0, in_pix) so the full 3x3 exists at acceptance time.
    logic [2:0][1:0][PIX_W-1:0] win;
    logic [2:0][2:0][PIX_W-1:0] nw;

    logic slot_free, acc, sof_acc, restart, pix_acc;
    logic at_first_out, last_pix, produce_in, produce_fl;
    logic interior, any_h, dec;

    assign slot_free = !out_valid || out_ready;
    // A new sof always restarts at pixel 0, whatever the counters say.
    assign pos_c = in_sof ? '0 : col;
    assign pos_r = in_sof ? '0 : row;
    assign at_first_out = (pos_r == RW'(1)) && (pos_c == CW'(1));
    assign last_pix = (pos_r == RW'(IMG_H - 1)) && (pos_c == CW'(IMG_W - 1));
    // Centre is (pos_r-1, pos_c-1); it is interior only when both are >= 1.
    assign interior = (pos_c >= CW'(2)) && (pos_r >= RW'(2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (sof_acc) state_nxt = FILL;
            FILL:  if (restart) state_nxt = FILL;
                   else if (pix_acc && at_first_out) state_nxt = RUN;
            RUN:   if (restart) state_nxt = FILL;
                   else if (pix_acc && last_pix) state_nxt = FLUSH;
            FLUSH: if (out_valid && out_ready && out_eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and per-cycle control strobes
    always_comb begin
        in_ready = 1'b1;
        case (state)
            RUN:     in_ready = slot_free;
            FLUSH:   in_ready = 1'b0;
            default: in_ready = 1'b1;
        endcase
        acc        = in_valid && in_ready;
        sof_acc    = acc && in_sof;
        restart    = sof_acc && (state != IDLE);
        pix_acc    = acc && (in_sof || (state != IDLE));
        produce_in = pix_acc && !in_sof &&
                     ((state == RUN) || ((state == FILL) && at_first_out));
        produce_fl = (state == FLUSH) && slot_free && (ocnt != OW'(NPIX));
    end

    // Neighbourhood assembly and hysteresis decision
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nw[i][0] = win[i][0];
            nw[i][1] = win[i][1];
        end
        nw[0][2] = lb1[pos_c];
        nw[1][2] = lb0[pos_c];
        nw[2][2] = in_pix;
        any_h = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (!(i == 1 && j == 1) && (nw[i][j] >= thr_h)) any_h = 1'b1;
        dec = (nw[1][1] >= thr_h) || (hyst_r && (nw[1][1] >= thr_l) && any_h);
    end

    // Line buffers hold no reset; border centres mask any stale content
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1[pos_c] <= lb0[pos_c];
            lb0[pos_c] <= in_pix;
        end
    end

    // Counters, window, frame-constant thresholds and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            ocnt      <= '0;
            win       <= '0;
            thr_h     <= '0;
            thr_l     <= '0;
            hyst_r    <= 1'b0;
            out_valid <= 1'b0;
            out_edge  <= 1'b0;
            out_eof   <= 1'b0;
            sof_err   <= 1'b0;
        end else begin
            sof_err <= restart;
            if (sof_acc) begin
                thr_h  <= thresh_h;
                thr_l  <= (thresh_l < thresh_h) ? thresh_l : thresh_h;
                hyst_r <= hyst_enable;
            end
            if (pix_acc) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= nw[i][1];
                    win[i][1] <= nw[i][2];
                end
                if (pos_c == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (pos_r == RW'(IMG_H - 1)) ? '0 : pos_r + RW'(1);
                end else begin
                    col <= pos_c + CW'(1);
                    row <= pos_r;
                end
            end
            if (sof_acc)
                ocnt <= '0;
            else if (produce_in || produce_fl)
                ocnt <= ocnt + OW'(1);
            if (restart) begin
                out_valid <= 1'b0;
                out_edge  <= 1'b0;
                out_eof   <= 1'b0;
            end else if (produce_in || produce_fl) begin
                out_valid <= 1'b1;
                out_edge  <= produce_in && interior && dec;
                out_eof   <= (ocnt == OW'(NPIX - 1));
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_edge  <= 1'b0;
                out_eof   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hysteresis_stream.sv
// Scoreboard bench for hysteresis_stream on a 4x4 image. Expected
// {edge,eof} pairs are queued as each frame is driven. They are popped on
// every output transfer.
module tb_hysteresis_stream;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, in_sof = 1'b0, hyst_enable = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] in_pix = '0, thresh_h = 8'd100, thresh_l = 8'd50;
    logic       in_ready, out_valid, out_edge, out_eof, sof_err;

    int         n_vec = 0, n_bad = 0;
    logic [1:0] sb[$];
    bit         rand_rdy = 1'b0;
    logic       last_sof_err = 1'b0;
    int         img[N];

    hysteresis_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_sof(in_sof), .thresh_h(thresh_h),
        .thresh_l(thresh_l), .hyst_enable(hyst_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_edge(out_edge),
        .out_eof(out_eof), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    // Sink readiness changes just after each rising edge
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: push the first cnt outputs of the frame in img
    task automatic push_frame(input int cnt);
        int hh, lf;
        hh = int'(thresh_h);
        lf = (thresh_l < thresh_h) ? int'(thresh_l) : int'(thresh_h);
        for (int k = 0; k < cnt; k++) begin
            int r, c;
            bit e, nb;
            r = k / W;
            c = k % W;
            e = 1'b0;
            nb = 1'b0;
            if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && img[(r + dr) * W + c + dc] >= hh) nb = 1'b1;
                e = (img[k] >= hh) || (hyst_enable && img[k] >= lf && nb);
            end
            sb.push_back({e, k == N - 1});
        end
    endtask

    // Drive one pixel; called and returns at a falling edge
    task automatic send(input logic [7:0] p, input logic s);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_pix = p;
        in_sof = s;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1 last_sof_err = sof_err;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_frame(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            send(8'(img[i]), i == 0);
            if (i == 0) chk("sof_no_err", 32'(last_sof_err), 32'(0));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_base();
        for (int i = 0; i < N; i++) img[i] = 60;
    endtask

    // Output monitor: backpressure rule and scoreboard pop
    always @(negedge clk) begin
        logic [1:0] e;
        if (out_valid && !out_ready) chk("bp_in_ready", 32'(in_ready), 32'(0));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("extra_output", 32'(out_valid), 32'(0));
            else begin
                e = sb.pop_front();
                chk("edge_eof", 32'({out_edge, out_eof}), 32'(e));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_edge", 32'(out_edge), 32'(0));
        chk("rst_out_eof", 32'(out_eof), 32'(0));
        chk("rst_sof_err", 32'(sof_err), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;

        // Non-sof pixels in IDLE are dropped and produce nothing
        send(8'd200, 1'b0);
        send(8'd200, 1'b0);

        // Single strong pixel at (1,2). All four interior centres touch it,
        // so join mode marks all four and high-only mode marks only (1,2).
        fill_base();
        img[1 * W + 2] = 120;
        hyst_enable = 1'b1;
        push_frame(N); send_frame(N); drain();
        hyst_enable = 1'b0;
        push_frame(N); send_frame(N); drain();

        // Low above high: effective low is the high threshold
        fill_base();
        img[1 * W + 1] = 120;
        thresh_l = 8'd150; thresh_h = 8'd100; hyst_enable = 1'b1;
        push_frame(N); send_frame(N); drain();

        // Random frames: first with a ready sink, then with random backpressure
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
            thresh_h = 8'($urandom_range(0, 255));
            thresh_l = 8'($urandom_range(0, 255));
            hyst_enable = 1'($urandom_range(0, 1));
            push_frame(N); send_frame(N); drain();
            rand_rdy = 1'b1;
            push_frame(N); send_frame(N); drain();
            rand_rdy = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Mid-frame sof at pixel 7. Border centres 0 and 1 of the
        // abandoned frame leave first; the new frame then gives 16 outputs.
        fill_base();
        img[1 * W + 2] = 120;
        thresh_h = 8'd100; thresh_l = 8'd50; hyst_enable = 1'b1;
        sb.push_back(2'b00);
        sb.push_back(2'b00);
        for (int i = 0; i < 7; i++) send(8'(img[i]), i == 0);
        push_frame(N);
        for (int i = 0; i < N; i++) begin
            send(8'(img[i]), i == 0);
            if (i == 0) chk("sof_err_pulse", 32'(last_sof_err), 32'(1));
            if (i == 1) chk("sof_err_clear", 32'(last_sof_err), 32'(0));
        end
        drain();

        // Reset during FLUSH. Centres 0..10 leave before the reset;
        // the rest, including eof, never appear.
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
        push_frame(11);
        for (int i = 0; i < N; i++) send(8'(img[i]), i == 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_rst_valid", 32'(out_valid), 32'(0));
        chk("flush_rst_eof", 32'(out_eof), 32'(0));
        chk("flush_rst_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        drain();

        // A following frame completes normally
        push_frame(N); send_frame(N); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
